// File: rtl/defines.sv
// Stall vector encodings and bit positions shared by the
// PC register and every inter-stage pipeline register.
package pipe_defines_pkg;

   localparam int STALL_W = 6;

   localparam int STALL_PC_BIT    = 0;
   localparam int STALL_IF_BIT    = 1;
   localparam int STALL_ID_BIT    = 2;
   localparam int STALL_EX_BIT    = 3;
   localparam int STALL_MEM_BIT   = 4;
   localparam int STALL_FLUSH_BIT = 5;

   localparam logic [STALL_W-1:0] STALL_NONE   = 6'b000000;
   localparam logic [STALL_W-1:0] STALL_LOAD   = 6'b000011;
   localparam logic [STALL_W-1:0] STALL_BRANCH = 6'b100000;
   localparam logic [STALL_W-1:0] STALL_DIV    = 6'b001111;
   localparam logic [STALL_W-1:0] STALL_MEM    = 6'b011111;

endpackage

// File: rtl/pipe_ctrl_pkg.sv
// Controller FSM state encoding for the pipeline stall
// sequencer.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      FLUSH    = 2'd1,
      DIV_WAIT = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/pipe_stall_ctrl.sv
// Central hazard controller: merges ID/EX/MEM hazards into
// one stall vector and sequences divide and flush stalls.
module pipe_stall_ctrl
   import pipe_defines_pkg::*;
   import pipe_ctrl_pkg::*;
#(
   parameter int DIV_LATENCY  = 4,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_use_i,
   input  logic               branch_taken_i,
   input  logic               div_start_i,
   input  logic               mem_wait_i,
   output logic [STALL_W-1:0] stall_o,
   output logic               div_busy_o,
   output logic               div_done_o,
   output logic               branch_pending_o
);

   localparam int MAX_C =
      (DIV_LATENCY > FLUSH_CYCLES) ? DIV_LATENCY : FLUSH_CYCLES;
   localparam int CW = $clog2(MAX_C) + 1;

   ctrl_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pend_q, pend_d;
   logic          done_q, done_d;

   logic cnt_zero;
   logic div_hold;
   logic br_flush;

   assign cnt_zero = (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      done_d  = 1'b0;
      unique case (state_q)
         RUN: begin
            if (mem_wait_i) begin
               if (branch_taken_i) pend_d = 1'b1;
            end else if (div_start_i) begin
               if (branch_taken_i) pend_d = 1'b1;
               if (DIV_LATENCY > 1) begin
                  state_d = DIV_WAIT;
                  cnt_d   = CW'(DIV_LATENCY - 1);
               end else begin
                  done_d = 1'b1;
               end
            end else if (branch_taken_i || pend_q) begin
               pend_d = 1'b0;
               if (FLUSH_CYCLES > 1) begin
                  state_d = FLUSH;
                  cnt_d   = CW'(FLUSH_CYCLES - 2);
               end
            end
         end
         DIV_WAIT: begin
            if (branch_taken_i) pend_d = 1'b1;
            if (!mem_wait_i) begin
               if (cnt_zero) state_d = RUN;
               else          cnt_d   = cnt_q - 1'b1;
            end
         end
         FLUSH: begin
            // a late branch is kept rather than dropped
            if (branch_taken_i) pend_d = 1'b1;
            if (!mem_wait_i) begin
               if (cnt_zero) state_d = RUN;
               else          cnt_d   = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase
      if (rst) begin
         state_d = RUN;
         cnt_d   = '0;
         pend_d  = 1'b0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
   end

   assign div_hold = ((state_q == DIV_WAIT) && !cnt_zero)
                  || ((state_q == RUN) && div_start_i);
   assign br_flush = (state_q == FLUSH)
                  || ((state_q == RUN)
                      && (branch_taken_i || pend_q));

   always_comb begin
      stall_o = STALL_NONE;
      if (rst)             stall_o = STALL_NONE;
      else if (mem_wait_i) stall_o = STALL_MEM;
      else if (div_hold)   stall_o = STALL_DIV;
      else if (br_flush)   stall_o = STALL_BRANCH;
      else if (load_use_i) stall_o = STALL_LOAD;
   end

   assign div_busy_o = !rst && (state_q == DIV_WAIT);
   assign div_done_o = !rst
      && (done_q || ((state_q == DIV_WAIT)
                     && cnt_zero && !mem_wait_i));
   assign branch_pending_o = pend_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl (DIV_LATENCY=4,
// FLUSH_CYCLES=2).
module tb_pipe_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_use_i;
   logic       branch_taken_i;
   logic       div_start_i;
   logic       mem_wait_i;
   logic [5:0] stall_o;
   logic       div_busy_o;
   logic       div_done_o;
   logic       branch_pending_o;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [5:0] S_NONE   = 6'b000000;
   localparam logic [5:0] S_LOAD   = 6'b000011;
   localparam logic [5:0] S_BRANCH = 6'b100000;
   localparam logic [5:0] S_DIV    = 6'b001111;
   localparam logic [5:0] S_MEM    = 6'b011111;

   pipe_stall_ctrl #(
      .DIV_LATENCY (4),
      .FLUSH_CYCLES(2)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .load_use_i      (load_use_i),
      .branch_taken_i  (branch_taken_i),
      .div_start_i     (div_start_i),
      .mem_wait_i      (mem_wait_i),
      .stall_o         (stall_o),
      .div_busy_o      (div_busy_o),
      .div_done_o      (div_done_o),
      .branch_pending_o(branch_pending_o)
   );

   always #5 clk = ~clk;

   // apply one cycle of inputs at the negedge, settle, then check
   task automatic drive(input logic r, input logic lu,
                        input logic br, input logic dv,
                        input logic mw);
      @(negedge clk);
      rst            = r;
      load_use_i     = lu;
      branch_taken_i = br;
      div_start_i    = dv;
      mem_wait_i     = mw;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 1, 0);
         n_checks++;
         if (stall_o !== S_NONE) begin
            n_fail++;
            $display("FAIL reset_stall cyc%0d got %b exp %b",
                     i, stall_o, S_NONE);
         end
         n_checks++;
         if (div_busy_o !== 1'b0 || div_done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_div cyc%0d busy %b done %b exp 0 0",
                     i, div_busy_o, div_done_o);
         end
      end
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 0);
         n_checks++;
         if (stall_o !== S_NONE || div_busy_o !== 1'b0
             || branch_pending_o !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset cyc%0d stall %b busy %b pend %b exp 000000 0 0",
                     i, stall_o, div_busy_o, branch_pending_o);
         end
      end
   endtask

   task automatic test_divide();
      logic [5:0] exp_s [0:5];
      logic       exp_b [0:5];
      logic       exp_d [0:5];
      exp_s = '{S_DIV, S_DIV, S_DIV, S_DIV, S_NONE, S_NONE};
      exp_b = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      exp_d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, 0, (i == 0), 0);
         n_checks++;
         if (stall_o !== exp_s[i] || div_busy_o !== exp_b[i]
             || div_done_o !== exp_d[i]) begin
            n_fail++;
            $display("FAIL divide cyc%0d got %b/%b/%b exp %b/%b/%b",
                     i, stall_o, div_busy_o, div_done_o,
                     exp_s[i], exp_b[i], exp_d[i]);
         end
      end
   endtask

   task automatic test_branch_flush();
      logic [5:0] exp_s [0:2];
      exp_s = '{S_BRANCH, S_BRANCH, S_NONE};
      for (int i = 0; i < 3; i++) begin
         drive(0, (i < 2), (i == 0), 0, 0);
         n_checks++;
         if (stall_o !== exp_s[i]) begin
            n_fail++;
            $display("FAIL branch_flush cyc%0d got %b exp %b",
                     i, stall_o, exp_s[i]);
         end
      end
   endtask

   task automatic test_branch_mem_wait();
      logic [5:0] exp_s [0:5];
      logic       exp_p [0:5];
      exp_s = '{S_MEM, S_MEM, S_MEM, S_BRANCH, S_BRANCH, S_NONE};
      exp_p = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, (i == 1), 0, (i < 3));
         n_checks++;
         if (stall_o !== exp_s[i] || branch_pending_o !== exp_p[i]) begin
            n_fail++;
            $display("FAIL branch_mem cyc%0d got %b/%b exp %b/%b",
                     i, stall_o, branch_pending_o, exp_s[i], exp_p[i]);
         end
      end
   endtask

   task automatic test_load_use();
      drive(0, 1, 0, 0, 0);
      n_checks++;
      if (stall_o !== S_LOAD) begin
         n_fail++;
         $display("FAIL load_use got %b exp %b", stall_o, S_LOAD);
      end
      drive(0, 0, 0, 0, 0);
      n_checks++;
      if (stall_o !== S_NONE) begin
         n_fail++;
         $display("FAIL load_use_clear got %b exp %b", stall_o, S_NONE);
      end
   endtask

   // divide extended by a memory wait, with a branch arriving mid-divide
   task automatic test_div_mem_branch();
      logic [5:0] exp_s [0:8];
      logic       exp_d [0:8];
      logic       exp_p [0:8];
      exp_s = '{S_DIV, S_DIV, S_MEM, S_DIV, S_DIV,
                S_NONE, S_BRANCH, S_BRANCH, S_NONE};
      exp_d = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
      exp_p = '{0, 0, 1, 1, 1, 1, 1, 0, 0};
      for (int i = 0; i < 9; i++) begin
         drive(0, 0, (i == 1), (i == 0), (i == 2));
         n_checks++;
         if (stall_o !== exp_s[i] || div_done_o !== exp_d[i]
             || branch_pending_o !== exp_p[i]) begin
            n_fail++;
            $display("FAIL div_mem_br cyc%0d got %b/%b/%b exp %b/%b/%b",
                     i, stall_o, div_done_o, branch_pending_o,
                     exp_s[i], exp_d[i], exp_p[i]);
         end
      end
   endtask

   task automatic test_reset_mid_div();
      drive(0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      n_checks++;
      if (stall_o !== S_NONE || div_busy_o !== 1'b0
          || div_done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_div_in got %b/%b/%b exp 000000/0/0",
                  stall_o, div_busy_o, div_done_o);
      end
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 0, 0);
         n_checks++;
         if (stall_o !== S_NONE || div_busy_o !== 1'b0
             || div_done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_div cyc%0d got %b/%b/%b exp 000000/0/0",
                     i, stall_o, div_busy_o, div_done_o);
         end
      end
   endtask

   initial begin
      rst            = 1'b1;
      load_use_i     = 1'b0;
      branch_taken_i = 1'b0;
      div_start_i    = 1'b0;
      mem_wait_i     = 1'b0;
      test_reset();
      idle(2);
      test_divide();
      idle(2);
      test_branch_flush();
      idle(2);
      test_branch_mem_wait();
      idle(2);
      test_load_use();
      idle(2);
      test_div_mem_branch();
      idle(2);
      test_reset_mid_div();
      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central hazard/stall controller for the 5-stage pipeline.
- Collects hazard requests from ID (load-use), EX (taken branch, multi-cycle divide) and MEM (data-memory wait).
- Produces the single 6-bit stall vector consumed by the PC register and all inter-stage pipeline registers, including the IF/ID register's flush-on-branch behaviour.
- Sequences multi-cycle divide stalls and multi-cycle branch flushes with an internal FSM and down-counter.

Parameters:
- DIV_LATENCY, 4, total cycles EX is held for a divide (>=1)
- FLUSH_CYCLES, 1, cycles the branch-flush code is driven after a taken branch (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- load_use_i  in  1  ID: load-use hazard detected this cycle
- branch_taken_i  in  1  EX: taken branch/jump this cycle
- div_start_i  in  1  EX: divide instruction entered EX this cycle
- mem_wait_i  in  1  MEM: data memory not ready, level
- stall_o  out  6  stall vector to PC and pipeline registers
- div_busy_o  out  1  FSM in DIV_WAIT
- div_done_o  out  1  one-cycle pulse when divide result is valid
- branch_pending_o  out  1  taken branch latched while blocked

Behaviour:
- stall_o encoding (constants in defines.sv):
  - STALL_NONE = 6'b000000
  - STALL_LOAD = 6'b000011: hold PC and IF/ID, bubble into ID/EX
  - STALL_BRANCH = 6'b100000: flush IF/ID instruction, no hold
  - STALL_DIV = 6'b001111: hold PC..ID/EX
  - STALL_MEM = 6'b011111: hold PC..EX/MEM
- stall_o is combinational from state, counter and inputs (same-cycle effect). Priority, first match wins:
  1. mem_wait_i -> STALL_MEM
  2. DIV_WAIT with cnt!=0, or RUN with div_start_i -> STALL_DIV
  3. FLUSH, or RUN with (branch_taken_i | pending) -> STALL_BRANCH
  4. load_use_i -> STALL_LOAD
  5. otherwise -> STALL_NONE
- load_use_i is ignored whenever rule 3 applies: the dependent instruction is squashed anyway.
- FSM states are RUN, FLUSH and DIV_WAIT. cnt width is $clog2(max(DIV_LATENCY,FLUSH_CYCLES))+1.
- RUN state:
  - mem_wait_i=1: no transition. branch_taken_i sets pending.
  - div_start_i: go to DIV_WAIT, cnt<=DIV_LATENCY-1. If DIV_LATENCY==1, pulse div_done_o next cycle and stay RUN. A simultaneous branch_taken_i sets pending.
  - branch_taken_i or pending: clear pending. If FLUSH_CYCLES>1, go to FLUSH with cnt<=FLUSH_CYCLES-2; otherwise stay RUN.
- DIV_WAIT state:
  - cnt decrements only in cycles with mem_wait_i=0.
  - When cnt==0 and mem_wait_i=0: div_done_o=1 for that cycle, stall rule 2 not applied, go to RUN.
  - branch_taken_i here sets pending.
- FLUSH state: cnt decrements when mem_wait_i=0. When cnt==0 and mem_wait_i=0, go to RUN.
- Latency: a divide produces exactly DIV_LATENCY STALL_DIV cycles, including the start cycle, when mem_wait_i is low. Each mem_wait_i cycle extends this by one.
- Simultaneous events: pending is never lost. It is applied in the first RUN cycle with mem_wait_i=0 and no div_start_i.
- Reset, including mid-divide or mid-flush:
  - Next state RUN, cnt=0, pending=0.
  - During rst, stall_o=STALL_NONE, div_done_o=0, div_busy_o=0.

Decomposition:
- defines.sv holds the STALL_* constants and the stall bit indices.
- A package pipe_ctrl_pkg holds the typedef enum {RUN, FLUSH, DIV_WAIT} ctrl_state_t.
- No sub-module: the FSM and down-counter stay in one module.

Test Plan:
- Reset: hold rst with div_start_i=1 -> stall_o=6'b000000, div_busy_o=0. After release with idle inputs, stall_o stays 0.
- Divide, DIV_LATENCY=4: div_start_i at cycle 0 -> stall_o=6'b001111 on cycles 0-3, div_done_o=1 on cycle 4, stall_o=0 on cycle 4.
- Branch, FLUSH_CYCLES=2: branch_taken_i at cycle 0 with load_use_i=1 on cycles 0-1 -> stall_o=6'b100000 on cycles 0-1, then 0 on cycle 2.
- Branch during memory wait: mem_wait_i=1 on cycles 0-2 and branch_taken_i at cycle 1 -> stall_o=6'b011111 on cycles 0-2, branch_pending_o=1 on cycles 2-3, stall_o=6'b100000 on cycle 3.
- Load-use alone: load_use_i=1 on one cycle -> stall_o=6'b000011 that cycle only.
- Reset mid-divide: rst asserted at cycle 2 of a DIV_LATENCY=4 divide -> after release state is RUN, no div_done_o pulse, stall_o=0.
